// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions.
//   DATA_W    : native datapath width in bits
//   word_t    : one datapath word
//   ALL_ONES  : word with every bit set
//   ALL_ZEROS : word with every bit clear
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    localparam word_t ALL_ONES  = '1;
    localparam word_t ALL_ZEROS = '0;

endpackage : alu_pkg

// File: rtl/and_1bit.sv
// Single-lane AND slice, built from a gate primitive.
// Ports:
//   out : a & b
//   a   : lane operand A
//   b   : lane operand B
module and_1bit (
    output logic out,
    input  logic a,
    input  logic b
);

    and u_and (out, a, b);

endmodule : and_1bit

// File: rtl/and_32bit.sv
// Registered bitwise AND unit for the ALU result mux.
// A WIDTH-lane array of and_1bit slices forms a & b; the result, a
// valid qualifier and zero/all-ones flags are registered on clk.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   in_valid  : capture a/b at this edge
//   a, b      : WIDTH-bit operands
//   out       : registered a & b (held while in_valid is low)
//   out_valid : out/flags hold a result captured at the last edge
//   zero      : registered, result is all zeros (1 in reset)
//   all_ones  : registered, result is all ones
module and_32bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero,
    output logic             all_ones
);

    logic [WIDTH-1:0] and_res;
    logic             res_zero;
    logic             res_ones;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        and_1bit u_slice (
            .out (and_res[i]),
            .a   (a[i]),
            .b   (b[i])
        );
    end

    always_comb begin
        res_zero = ~|and_res;
        res_ones = &and_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b1;
            all_ones  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Result and flags hold when no new operands arrive.
            if (in_valid) begin
                out      <= and_res;
                zero     <= res_zero;
                all_ones <= res_ones;
            end
        end
    end

endmodule : and_32bit

// File: tb/tb_and_32bit.sv
// Self-checking bench for and_32bit using an expected-result queue.
module tb_and_32bit;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic        ones;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        out_valid;
    logic        zero;
    logic        all_ones;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];
    exp_t        last;

    and_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero),
        .all_ones  (all_ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        e.data = av & bv;
        e.zero = ($countones(e.data) == 0);
        e.ones = ($countones(e.data) == 32);
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_out"}, out, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_zero"}, zero, 1);
        check({tag, "_ones"}, all_ones, 0);
    endtask

    // Compare DUT state just after an edge at which in_valid was v.
    task automatic check_after_edge(input string tag, input logic v);
        exp_t e;
        check({tag, "_valid"}, out_valid, v);
        if (v) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 1, 0);
                return;
            end
            e = sb.pop_front();
            last = e;
        end
        check({tag, "_out"}, out, last.data);
        check({tag, "_zero"}, zero, last.zero);
        check({tag, "_ones"}, all_ones, last.ones);
    endtask

    task automatic drive_cycle(input string tag, input logic v,
                               input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        in_valid = v;
        a = av;
        b = bv;
        if (v) sb.push_back(make_exp(av, bv));
        @(posedge clk);
        #1;
        check_after_edge(tag, v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rv;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        last.data = '0;
        last.zero = 1'b1;
        last.ones = 1'b0;

        // Reset values before any clock edge.
        #1;
        check_reset_vals("reset_no_clk");
        @(negedge clk);
        rst = 1'b0;

        drive_cycle("all_ones", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        drive_cycle("dir0", 1'b1, 32'h0000_0000, 32'h0000_0001);
        drive_cycle("dir1", 1'b1, 32'h0000_0001, 32'h0000_0000);
        drive_cycle("dir2", 1'b1, 32'h0000_0001, 32'h0000_0001);

        drive_cycle("alt_aa55", 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
        drive_cycle("alt_f0ff", 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("alt_f0ff_const", out, 32'hF000_F000);

        drive_cycle("cap", 1'b1, 32'h1234_5678, 32'hFFFF_0000);
        check("cap_const", out, 32'h1234_0000);
        for (int i = 0; i < 3; i++) begin
            drive_cycle("hold", 1'b0, $urandom, $urandom);
            check("hold_const", out, 32'h1234_0000);
        end

        // Asynchronous reset pulse between edges with a capture pending.
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        sb.push_back(make_exp(a, b));
        #1 rst = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        last.data = '0;
        last.zero = 1'b1;
        last.ones = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check_after_edge("post_reset", 1'b1);
        check("post_reset_const", out, 32'hFFFF_FFFF);

        for (int i = 0; i < 1000; i++) begin
            rv = ($urandom_range(3, 0) != 0);
            ra = $urandom;
            rb = $urandom;
            if (i % 50 == 0) rb = ~ra;
            if (i % 77 == 0) begin
                ra = '1;
                rb = '1;
            end
            drive_cycle("rand", rv, ra, rb);
        end

        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_and_32bit

// File: doc/and_32bit.md
Name: and_32bit

Overview:
- Registered 32-bit bitwise AND unit for the ALU datapath: out = a & b, one bit per lane.
- Built structurally from a 1-bit AND slice replicated WIDTH times.
- Result and status flags are captured on the clock with a valid qualifier, so the block drops into the pipelined ALU result mux.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  a/b are presented this cycle and must be captured
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out  output  WIDTH  registered a & b
- out_valid  output  1  out and flags hold a new result
- zero  output  1  registered: result is all zeros
- all_ones  output  1  registered: result is all ones

Interface decision (fixed): one clock; reset is asynchronous and active-high (clk, rst).

Behaviour:
- Combinational stage: and_res[i] = a[i] & b[i] for i in 0..WIDTH-1, with no carries or cross-bit interaction.
- On rst = 1, immediately and without a clock edge:
  - out = 0, out_valid = 0, zero = 1, all_ones = 0.
  - These values are held while rst is asserted.
- Rising clk edge with rst = 0 and in_valid = 1:
  - out <= and_res, out_valid <= 1.
  - zero <= (and_res == 0).
  - all_ones <= (and_res == all ones).
- Rising clk edge with rst = 0 and in_valid = 0:
  - out, zero and all_ones hold their previous values.
  - out_valid <= 0.
- Latency: exactly 1 cycle from in_valid sampled high to out_valid high. Throughput: one result per cycle with back-to-back in_valid.
- No backpressure. The consumer must accept out on the cycle out_valid = 1; the result persists afterwards but is not revalidated.
- Reset asserted mid-operation: any pending capture is discarded and outputs take reset values asynchronously. The first post-reset capture needs a rising edge with rst already low and in_valid = 1.
- Flags are mutually exclusive for WIDTH >= 1. They are never both 1 after a valid capture.
- Operands with X/Z bits are not supported. Inputs are sampled only at the edge.

Decomposition:
- Shared package alu_pkg:
  - DATA_W = 32 constant.
  - typedef word_t = logic [DATA_W-1:0].
  - ALL_ONES / ALL_ZEROS constants.
- Sub-module and_1bit (out, a, b) is a single gate-level AND slice, instantiated WIDTH times via generate.
- Flag reduction and output registers live in and_32bit.

Test Plan:
1. Assert rst with no clock -> out = 0x00000000, out_valid = 0, zero = 1, all_ones = 0 immediately.
2. a = 0xFFFFFFFF, b = 0xFFFFFFFF, in_valid = 1, one edge -> out = 0xFFFFFFFF, out_valid = 1, all_ones = 1, zero = 0.
3. Directed sequence, one capture per edge, in_valid = 1 each cycle:
   - a = 0x00000000, b = 0x00000001 -> out = 0x00000000, zero = 1.
   - then a = 0x00000001, b = 0x00000000 -> out = 0x00000000, zero = 1.
   - then a = 0x00000001, b = 0x00000001 -> out = 0x00000001, zero = 0, all_ones = 0.
   - out_valid stays 1 throughout.
4. Alternating patterns:
   - a = 0xAAAAAAAA, b = 0x55555555 -> out = 0x00000000, zero = 1.
   - a = 0xF0F0F0F0, b = 0xFF00FF00 -> out = 0xF000F000.
5. Capture a = 0x12345678, b = 0xFFFF0000, then drop in_valid for 3 cycles -> out stays 0x12340000, out_valid = 1 for one cycle then 0.
6. Reset mid-stream:
   - Mid-cycle, with in_valid = 1 and a = b = 0xFFFFFFFF, pulse rst between edges -> out = 0 and out_valid = 0 immediately.
   - Next edge with rst = 0 -> out = 0xFFFFFFFF, out_valid = 1.
   - Random a/b for 1000 cycles -> out always equals the previous cycle's a & b.
